ntt_loop_ctrl: RTL and testbench



---
 rtl/ntt_loop_ctrl_pkg.sv | 20 ++
 rtl/ntt_loop_ctrl_if.sv | 24 ++
 rtl/ntt_lane_addr.sv | 18 +
 rtl/ntt_loop_ctrl.sv | 136 +++++++++++++
 tb/tb_ntt_loop_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_loop_ctrl_pkg.sv
// Shared constants and FSM state type for the NTT butterfly sequencer.
package ntt_loop_ctrl_pkg;

  localparam int NTT_N    = 1024;
  localparam int NTT_LOGN = 10;
  localparam int NTT_D    = 4;

  // Field widths: stage half-distance, twiddle sub-index, data address
  localparam int JW = 10;
  localparam int IW = 7;
  localparam int AW = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ntt_loop_ctrl_if.sv
// Butterfly-group issue bus: one D-lane group per valid/ready transfer.
interface ntt_loop_ctrl_if
  import ntt_loop_ctrl_pkg::*;
  ();

  logic                  bf_valid;
  logic                  bf_ready;
  logic [JW-1:0]         J;
  logic [IW-1:0]         i;
  logic [NTT_D*AW-1:0]   top_addr;
  logic [NTT_D*AW-1:0]   bot_addr;
  logic                  last_in_stage;

  modport master (
    output bf_valid, J, i, top_addr, bot_addr, last_in_stage,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, J, i, top_addr, bot_addr, last_in_stage,
    output bf_ready
  );

endinterface

// File: rtl/ntt_lane_addr.sv
// Top/bottom data addresses of one butterfly k in the stage with half-distance j.
module ntt_lane_addr
  import ntt_loop_ctrl_pkg::*;
(
  input  logic [AW-1:0] k,
  input  logic [JW-1:0] j,
  output logic [AW-1:0] top,
  output logic [AW-1:0] bot
);

  logic [AW-1:0] mask;

  // ((k >> s) << (s+1)) is the bits of k above the mask moved up by one
  assign mask = AW'(j) - AW'(1);
  assign top  = ((k & ~mask) << 1) | (k & mask);
  assign bot  = top + AW'(j);

endmodule

// File: rtl/ntt_loop_ctrl.sv
// Stage/group sequencer for the NTT butterfly array with a drain barrier per stage.
module ntt_loop_ctrl
  import ntt_loop_ctrl_pkg::*;
#(
  parameter int N    = NTT_N,
  parameter int LOGN = NTT_LOGN,
  parameter int D    = NTT_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            drain_done,
  output logic            busy,
  output logic            done,
  ntt_loop_ctrl_if.master bf
);

  localparam int CW = LOGN - $clog2(D) - 1;
  localparam logic [JW-1:0] J_FIRST = JW'(N / 2);
  localparam logic [CW-1:0] C_LAST  = '1;

  state_t              state_reg;
  logic [CW-1:0]       c_reg, c_nxt;
  logic [JW-1:0]       j_reg, j_nxt;
  logic [IW-1:0]       i_reg, i_nxt;
  logic [D*AW-1:0]     top_reg, top_nxt;
  logic [D*AW-1:0]     bot_reg, bot_nxt;
  logic                last_reg, last_nxt;
  logic                valid_reg, busy_reg, done_reg;
  logic [JW-1:0]       jq;
  logic                load;

  // Candidate (c, J) for the group presented after this cycle's event
  always_comb begin
    c_nxt = c_reg + CW'(1);
    j_nxt = j_reg;
    if (state_reg == IDLE) begin
      c_nxt = '0;
      j_nxt = J_FIRST;
    end else if (state_reg == DRAIN) begin
      c_nxt = '0;
      j_nxt = j_reg >> 1;
    end
  end

  assign jq       = (j_nxt >> 2) - JW'(1);
  assign i_nxt    = (j_nxt < JW'(4)) ? '0 : IW'(JW'(c_nxt) & jq);
  assign last_nxt = (c_nxt == C_LAST);

  for (genvar gi = 0; gi < D; gi++) begin : g_lane
    logic [AW-1:0] k;
    assign k = AW'(D * int'(c_nxt) + gi);
    ntt_lane_addr u_lane (
      .k   (k),
      .j   (j_nxt),
      .top (top_nxt[gi*AW +: AW]),
      .bot (bot_nxt[gi*AW +: AW])
    );
  end

  assign load = ((state_reg == IDLE)  && start) ||
                ((state_reg == ISSUE) && bf.bf_ready && (c_reg != C_LAST)) ||
                ((state_reg == DRAIN) && drain_done && (j_reg != JW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      j_reg     <= J_FIRST;
      i_reg     <= '0;
      top_reg   <= '0;
      bot_reg   <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ISSUE;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          if (bf.bf_ready && (c_reg == C_LAST)) begin
            state_reg <= DRAIN;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            c_reg     <= '0;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            if (j_reg == JW'(1)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
              j_reg     <= J_FIRST;
              i_reg     <= '0;
              top_reg   <= '0;
              bot_reg   <= '0;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
      // All group fields move together so they stay stable under backpressure
      if (load) begin
        valid_reg <= 1'b1;
        c_reg     <= c_nxt;
        j_reg     <= j_nxt;
        i_reg     <= i_nxt;
        top_reg   <= top_nxt;
        bot_reg   <= bot_nxt;
        last_reg  <= last_nxt;
      end
    end
  end

  assign busy             = busy_reg;
  assign done             = done_reg;
  assign bf.bf_valid      = valid_reg;
  assign bf.J             = j_reg;
  assign bf.i             = i_reg;
  assign bf.top_addr      = top_reg;
  assign bf.bot_addr      = bot_reg;
  assign bf.last_in_stage = last_reg;

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Self-checking bench for ntt_loop_ctrl: scoreboard of all groups plus hand-derived vectors.
module tb_ntt_loop_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic drain_done = 1'b0;
  logic busy, done;

  ntt_loop_ctrl_if bf ();

  ntt_loop_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .drain_done (drain_done),
    .busy       (busy),
    .done       (done),
    .bf         (bf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  j;
    logic [6:0]  i;
    logic [39:0] top;
    logic [39:0] bot;
    logic        last;
  } grp_t;

  typedef struct {
    int          stage;
    int          c;
    logic [39:0] top;
    logic [39:0] bot;
    logic [6:0]  i;
    logic        last;
  } vec_t;

  grp_t q[$];
  vec_t tbl[6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stage_t, c_t, xfer_cnt, last_cnt, done_cnt, done_cyc, first_valid_cyc;
  int drain_cnt, drain_delay, stall_left, rise_cyc, hits;
  bit stall_en, stall_done, hold_start, abort_en, aborted, spur_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference using the shift formula with s = log2(J)
  function automatic grp_t model(input int stage, input int c);
    grp_t g;
    int jj, s, k, t;
    jj = 512 >> stage;
    s  = 9 - stage;
    g.j = 10'(jj);
    g.i = (jj >= 4) ? 7'(c & (jj / 4 - 1)) : 7'd0;
    g.last = (c == 127);
    g.top = '0;
    g.bot = '0;
    for (int l = 0; l < 4; l++) begin
      k = 4 * c + l;
      t = ((k >> s) << (s + 1)) | (k & (jj - 1));
      g.top[10*l +: 10] = 10'(t);
      g.bot[10*l +: 10] = 10'(t + jj);
    end
    return g;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(bf.bf_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_last"},  64'(bf.last_in_stage), 64'd0);
    chk({tag, "_J"},     64'(bf.J), 64'd512);
    chk({tag, "_i"},     64'(bf.i), 64'd0);
    chk({tag, "_top"},   64'(bf.top_addr), 64'd0);
    chk({tag, "_bot"},   64'(bf.bot_addr), 64'd0);
  endtask

  task automatic drive_next();
    grp_t g;
    drain_done = 1'b0;
    bf.bf_ready = 1'b1;
    if (drain_cnt > 0) begin
      drain_cnt--;
      if (drain_cnt == 0) drain_done = 1'b1;
    end
    // Stray drain_done during ISSUE must be ignored
    if (stall_en && !spur_done && stage_t == 0 && c_t == 10) begin
      drain_done = 1'b1;
      spur_done  = 1'b1;
    end
    if (stall_en && !stall_done && stall_left == 0 && stage_t == 0 && c_t == 40 && bf.bf_valid)
      stall_left = 5;
    if (stall_left > 0) begin
      g = model(0, 40);
      bf.bf_ready = 1'b0;
      chk("stall_valid", 64'(bf.bf_valid), 64'd1);
      chk("stall_top", 64'(bf.top_addr), 64'(g.top));
      chk("stall_i", 64'(bf.i), 64'(g.i));
      stall_left--;
      if (stall_left == 0) begin
        stall_done = 1'b1;
        rise_cyc   = cyc + 1;
      end
    end
    if (stall_done && cyc == rise_cyc + 1) begin
      g = model(0, 41);
      chk("post_stall_valid", 64'(bf.bf_valid), 64'd1);
      chk("post_stall_top", 64'(bf.top_addr), 64'(g.top));
    end
    if (!hold_start || (done_cnt > 0 && cyc > done_cyc)) start = 1'b0;
    if (abort_en && !aborted && stage_t == 3 && c_t == 30 && bf.bf_valid) begin
      rst_n = 1'b0;
      #1;
      chk_reset_values("async_rst");
      aborted = 1'b1;
      q.delete();
    end
  endtask

  task automatic monitor();
    grp_t e;
    if (!rst_n) return;
    if (bf.bf_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
      chk("busy_at_done", 64'(busy), 64'd1);
    end
    if (done_cnt > 0 && cyc == done_cyc + 1) begin
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("valid_after_done", 64'(bf.bf_valid), 64'd0);
    end
    if (bf.bf_valid && bf.bf_ready) begin
      $display("xfer stage=%0d c=%0d J=%0d i=%0d top=%h bot=%h last=%0d",
               stage_t, c_t, bf.J, bf.i, bf.top_addr, bf.bot_addr, bf.last_in_stage);
      if (q.size() == 0) begin
        chk("unexpected_xfer", 64'(xfer_cnt), 64'd1280);
      end else begin
        e = q.pop_front();
        chk("sb_J", 64'(bf.J), 64'(e.j));
        chk("sb_i", 64'(bf.i), 64'(e.i));
        chk("sb_top", 64'(bf.top_addr), 64'(e.top));
        chk("sb_bot", 64'(bf.bot_addr), 64'(e.bot));
        chk("sb_last", 64'(bf.last_in_stage), 64'(e.last));
      end
      for (int t = 0; t < 6; t++) begin
        if (tbl[t].stage == stage_t && tbl[t].c == c_t) begin
          hits++;
          chk("vec_top", 64'(bf.top_addr), 64'(tbl[t].top));
          chk("vec_bot", 64'(bf.bot_addr), 64'(tbl[t].bot));
          chk("vec_i", 64'(bf.i), 64'(tbl[t].i));
          chk("vec_last", 64'(bf.last_in_stage), 64'(tbl[t].last));
        end
      end
      xfer_cnt++;
      if (bf.last_in_stage) last_cnt++;
      if (c_t == 127) begin
        c_t = 0;
        stage_t++;
        drain_cnt = drain_delay;
      end else begin
        c_t++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    drive_next();
    monitor();
  endtask

  task automatic run(input int delay, input bit stall_i, input bit hold_i, input bit abort_i);
    stage_t = 0; c_t = 0; xfer_cnt = 0; last_cnt = 0; done_cnt = 0; done_cyc = 0;
    first_valid_cyc = -1; drain_cnt = 0; drain_delay = delay; stall_left = 0; rise_cyc = 0;
    hits = 0; stall_en = stall_i; stall_done = 0; hold_start = hold_i; abort_en = abort_i;
    aborted = 0; spur_done = !stall_i;
    q.delete();
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < 128; c++) q.push_back(model(s, c));
    @(negedge clk);
    start = 1'b1;
    bf.bf_ready = 1'b1;
    cycle();
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_valid", 64'(bf.bf_valid), 64'd1);
    chk("start_J", 64'(bf.J), 64'd512);
    for (int n = 0; n < 4000; n++) begin
      if (aborted || (done_cnt > 0 && cyc >= done_cyc + 2)) break;
      cycle();
    end
    if (!aborted) begin
      chk("done_seen_in_budget", 64'(done_cnt > 0), 64'd1);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("xfer_count", 64'(xfer_cnt), 64'd1280);
      chk("last_count", 64'(last_cnt), 64'd10);
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("vec_hits", 64'(hits), 64'd6);
      chk("run_length", 64'(done_cyc - first_valid_cyc + 1),
          64'(10 * (128 + delay) + 1 + (stall_i ? 5 : 0)));
    end
  endtask

  initial begin
    tbl[0] = '{stage: 0, c: 0,   top: {10'd3, 10'd2, 10'd1, 10'd0},
               bot: {10'd515, 10'd514, 10'd513, 10'd512}, i: 7'd0, last: 1'b0};
    tbl[1] = '{stage: 0, c: 127, top: {10'd511, 10'd510, 10'd509, 10'd508},
               bot: {10'd1023, 10'd1022, 10'd1021, 10'd1020}, i: 7'd127, last: 1'b1};
    tbl[2] = '{stage: 6, c: 2,   top: {10'd19, 10'd18, 10'd17, 10'd16},
               bot: {10'd27, 10'd26, 10'd25, 10'd24}, i: 7'd0, last: 1'b0};
    tbl[3] = '{stage: 6, c: 3,   top: {10'd23, 10'd22, 10'd21, 10'd20},
               bot: {10'd31, 10'd30, 10'd29, 10'd28}, i: 7'd1, last: 1'b0};
    tbl[4] = '{stage: 9, c: 5,   top: {10'd46, 10'd44, 10'd42, 10'd40},
               bot: {10'd47, 10'd45, 10'd43, 10'd41}, i: 7'd0, last: 1'b0};
    tbl[5] = '{stage: 3, c: 30,  top: {10'd187, 10'd186, 10'd185, 10'd184},
               bot: {10'd251, 10'd250, 10'd249, 10'd248}, i: 7'd14, last: 1'b0};

    bf.bf_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("idle");

    // Backpressure at c=40, stray drain_done, drain 3 cycles late, start held high
    run(3, 1'b1, 1'b1, 1'b0);

    // Abort in stage J=64 at c=30
    run(1, 1'b0, 1'b0, 1'b1);
    chk("abort_happened", 64'(aborted), 64'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_values("held_rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("post_rst");

    // Restart from J=512, c=0 with minimum drain latency
    run(1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
